jtpang_pcmrom: RTL and testbench
================================

JTPANG_PCMROM -- requirements
Module: jtpang_pcmrom

Interface
REQ-001 Parameter OFFSET, 22'd0, SDRAM word offset of the PCM region in its bank.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pcm_cs  in  1  sound block requests a PCM byte.
REQ-005 pcm_addr  in  18  PCM byte address.
REQ-006 pcm_data  out  8  selected byte.
REQ-007 pcm_ok  out  1  pcm_data valid for current pcm_addr.
REQ-008 sdram_addr  out  22  SDRAM word address.
REQ-009 sdram_rd  out  1  read request.
REQ-010 sdram_ack  in  1  request accepted.
REQ-011 sdram_rdy  in  1  data_read valid, one-cycle pulse.
REQ-012 data_read  in  16  SDRAM read data.

Function
REQ-013 Word address wa = pcm_addr[17:1]; byte select pcm_addr[0]=0 -> word[7:0], 1 -> word[15:8].
REQ-014 Two 16-bit buffers, each with 17-bit tag and valid: A (current) and P (prefetch).
REQ-015 pcm_ok combinational = pcm_cs & A.valid & (A.tag==wa); pcm_data from A, byte per REQ-013, regardless of pcm_ok.
REQ-016 FSM states IDLE, REQ, WAIT; one transaction outstanding at most.
REQ-017 IDLE, pcm_cs high, A misses, P hits: copy P into A next cycle, P.valid cleared; no SDRAM access.
REQ-018 IDLE, pcm_cs high, A and P miss: demand fetch of wa, enter REQ.
REQ-019 IDLE, pcm_cs high, A hits, P not holding wa+1: prefetch fetch of wa+1, enter REQ.
REQ-020 Demand has priority over prefetch when both apply in the same cycle.
REQ-021 wa+1 wraps modulo 2^17 (17'h1FFFF -> 17'h00000).
REQ-022 sdram_addr = OFFSET + fetch word address, modulo 2^22, registered and stable from REQ entry until WAIT exit.
REQ-023 REQ: sdram_rd high; on sdram_ack go to WAIT with sdram_rd low the following cycle.
REQ-024 WAIT: on sdram_rdy capture data_read into target buffer (A for demand, P for prefetch), set tag and valid, return to IDLE.
REQ-025 Target buffer and tag latched at fetch issue; pcm_addr changes during REQ/WAIT do not abort or redirect the fetch.
REQ-026 After any fetch completes, IDLE re-evaluates REQ-017..019 against the then-current pcm_addr.
REQ-027 pcm_cs low: no new fetch issued; an in-flight fetch completes normally.
REQ-028 sdram_rdy outside WAIT ignored; sdram_ack outside REQ ignored.
REQ-029 Demand miss latency: pcm_ok high in the cycle after the sdram_rdy capture cycle.
REQ-030 P hit latency: pcm_ok high one cycle after miss detection.

Reset
REQ-031 rst high: state IDLE, sdram_rd 0, sdram_addr 0, A.valid 0, P.valid 0, tags 0, data buffers 0; pcm_ok 0, pcm_data 0.
REQ-032 rst mid-transaction abandons fetch; subsequent sdram_rdy ignored per REQ-028.
REQ-033 Outputs fixed at reset values while rst high, regardless of inputs.

Verification
REQ-034 OFFSET=22'h10000, pcm_cs=1, pcm_addr=18'h00005 after reset -> sdram_addr=22'h10002, sdram_rd until ack; rdy with data_read=16'hA55A -> next cycle pcm_ok=1, pcm_data=8'hA5.
REQ-035 Continue from REQ-034 -> prefetch issued at sdram_addr=22'h10003 with data 16'h1234; pcm_addr=18'h00006 -> pcm_ok one cycle later, pcm_data=8'h34, no SDRAM request.
REQ-036 pcm_addr=18'h3FFFF demand fetch (word 17'h1FFFF, OFFSET 0) -> prefetch sdram_addr=22'h00000.
REQ-037 pcm_addr changed to 18'h00100 while demand for 18'h00005 in WAIT -> data lands in A tag 17'h00002, pcm_ok stays 0, new demand sdram_addr=22'h00080 issued next IDLE.
REQ-038 rst asserted in WAIT, then sdram_rdy pulse -> sdram_rd 0, pcm_ok 0, no buffer valid; first fetch after rst re-requests.
REQ-039 pcm_cs=0 in IDLE with A miss -> sdram_rd stays 0 indefinitely.

Source files
------------

// File: rtl/jtpang_pcmrom.sv
// Two-word PCM byte cache in front of SDRAM: buffer A serves the sound block,
// buffer P is filled with the following word so sequential playback rarely stalls.
module jtpang_pcmrom #(
  parameter logic [21:0] OFFSET = 22'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcm_cs,
  input  logic [17:0] pcm_addr,
  output logic [7:0]  pcm_data,
  output logic        pcm_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_rd,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [15:0] data_read
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q;
  logic [15:0] aData_q, pData_q;
  logic [16:0] aTag_q, pTag_q;
  logic        aValid_q, pValid_q;
  logic [16:0] fetchTag_q;
  logic        fetchToP_q;
  logic [21:0] sdramAddr_q;
  logic        sdramRd_q;

  logic [16:0] wordAddr, nextWord;
  logic        aHit, pHit, pHoldsNext;
  logic        copyP_d, demand_d, prefetch_d;
  logic [16:0] fetchTag_d;

  assign wordAddr   = pcm_addr[17:1];
  assign nextWord   = wordAddr + 17'd1;
  assign aHit       = aValid_q && (aTag_q == wordAddr);
  assign pHit       = pValid_q && (pTag_q == wordAddr);
  assign pHoldsNext = pValid_q && (pTag_q == nextWord);

  // Demand outranks prefetch; a P hit is served locally without touching SDRAM.
  always_comb begin
    copyP_d    = 1'b0;
    demand_d   = 1'b0;
    prefetch_d = 1'b0;
    fetchTag_d = wordAddr;
    if (state_q == IDLE && pcm_cs) begin
      if (!aHit && pHit) begin
        copyP_d = 1'b1;
      end else if (!aHit) begin
        demand_d = 1'b1;
      end else if (!pHoldsNext) begin
        prefetch_d = 1'b1;
        fetchTag_d = nextWord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      aData_q     <= 16'd0;
      pData_q     <= 16'd0;
      aTag_q      <= 17'd0;
      pTag_q      <= 17'd0;
      aValid_q    <= 1'b0;
      pValid_q    <= 1'b0;
      fetchTag_q  <= 17'd0;
      fetchToP_q  <= 1'b0;
      sdramAddr_q <= 22'd0;
      sdramRd_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (copyP_d) begin
            aData_q  <= pData_q;
            aTag_q   <= pTag_q;
            aValid_q <= 1'b1;
            pValid_q <= 1'b0;
          end else if (demand_d || prefetch_d) begin
            fetchTag_q  <= fetchTag_d;
            fetchToP_q  <= prefetch_d;
            sdramAddr_q <= OFFSET + {5'd0, fetchTag_d};
            sdramRd_q   <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (sdram_ack) begin
            sdramRd_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          // Destination was fixed at issue time, whatever pcm_addr does now.
          if (sdram_rdy) begin
            if (fetchToP_q) begin
              pData_q  <= data_read;
              pTag_q   <= fetchTag_q;
              pValid_q <= 1'b1;
            end else begin
              aData_q  <= data_read;
              aTag_q   <= fetchTag_q;
              aValid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are forced to their reset values for the whole time rst is high.
  assign pcm_ok     = !rst && pcm_cs && aHit;
  assign pcm_data   = rst ? 8'd0 : (pcm_addr[0] ? aData_q[15:8] : aData_q[7:0]);
  assign sdram_addr = rst ? 22'd0 : sdramAddr_q;
  assign sdram_rd   = !rst && sdramRd_q;

endmodule

// File: tb/tb_jtpang_pcmrom.sv
// Bench for jtpang_pcmrom: directed scenarios with a hand-driven SDRAM, then
// random playback against an SDRAM model with a queue-based scoreboard.
module tb_jtpang_pcmrom;

  localparam logic [21:0] OFFS = 22'h10000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcm_cs;
  logic [17:0] pcm_addr;
  logic [7:0]  pcm_data;
  logic        pcm_ok;
  logic [21:0] sdram_addr;
  logic        sdram_rd;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] data_read;

  int total = 0;
  int bad   = 0;

  logic [7:0] expQ[$];
  bit         pending   = 1'b0;
  int         served    = 0;
  bit         autoMem   = 1'b0;
  bit         scoreOn   = 1'b0;

  jtpang_pcmrom #(.OFFSET(OFFS)) dut (
    .clk(clk), .rst(rst), .pcm_cs(pcm_cs), .pcm_addr(pcm_addr),
    .pcm_data(pcm_data), .pcm_ok(pcm_ok), .sdram_addr(sdram_addr),
    .sdram_rd(sdram_rd), .sdram_ack(sdram_ack), .sdram_rdy(sdram_rdy),
    .data_read(data_read)
  );

  always #5 clk = ~clk;

  // Contents of the PCM region, indexed by 17-bit word number.
  function automatic logic [15:0] memWord(input logic [16:0] w);
    logic [31:0] h;
    h = {15'd0, w} * 32'd2654435761;
    return h[31:16] ^ w[15:0];
  endfunction

  function automatic logic [7:0] memByte(input logic [17:0] a);
    logic [15:0] w;
    w = memWord(a[17:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReq(input logic [21:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    while (!sdram_rd && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_rd"}, {31'd0, sdram_rd}, 32'd1);
    checkOutput({name, "_addr"}, {10'd0, sdram_addr}, {10'd0, exp});
  endtask

  task automatic serveFetch(input logic [21:0] exp, input logic [15:0] data,
                            input bit demand, input string name);
    waitReq(exp, name);
    cyc(); sdram_ack = 1'b1;
    cyc(); sdram_ack = 1'b0;
    @(negedge clk);
    checkOutput({name, "_rdLow"}, {31'd0, sdram_rd}, 32'd0);
    cyc(); sdram_rdy = 1'b1; data_read = data;
    @(negedge clk);
    if (demand) checkOutput({name, "_okEarly"}, {31'd0, pcm_ok}, 32'd0);
    cyc(); sdram_rdy = 1'b0;
  endtask

  // Random-phase request: expected byte goes on the queue, the monitor retires it.
  task automatic applyStimulus(input logic [17:0] a);
    int prev;
    int n = 0;
    prev     = served;
    pcm_addr = a;
    pcm_cs   = 1'b1;
    expQ.push_back(memByte(a));
    pending  = 1'b1;
    while (served == prev && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (served == prev) begin
      total++;
      bad++;
      $display("[TB] FAIL serveTimeout: addr %h never got pcm_ok", a);
      pending = 1'b0;
      if (expQ.size() > 0) void'(expQ.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (scoreOn && pending && pcm_cs && pcm_ok) begin
      logic [7:0] e;
      e = expQ.pop_front();
      checkOutput("pcmByte", {24'd0, pcm_data}, {24'd0, e});
      pending = 1'b0;
      served++;
    end
  end

  // Autonomous SDRAM: random ack/rdy delays, plus stray rdy pulses while idle.
  initial begin
    logic [21:0] reqAddr, idx;
    forever begin
      @(posedge clk);
      #1;
      if (autoMem) begin
        sdram_rdy = 1'b0;
        sdram_ack = 1'b0;
        if (sdram_rd) begin
          reqAddr = sdram_addr;
          idx     = reqAddr - OFFS;
          checkOutput("sdAddrRange", {27'd0, idx[21:17]}, 32'd0);
          repeat ($urandom_range(0, 3)) cyc();
          sdram_ack = 1'b1;
          cyc();
          sdram_ack = 1'b0;
          repeat ($urandom_range(0, 4)) cyc();
          checkOutput("sdAddrStable", {10'd0, sdram_addr}, {10'd0, reqAddr});
          sdram_rdy = 1'b1;
          data_read = memWord(idx[16:0]);
        end else if ($urandom_range(0, 9) == 0) begin
          sdram_rdy = 1'b1;
          data_read = 16'($urandom);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [17:0] curAddr;
    int seen;
    int r;

    rst = 1'b1; pcm_cs = 1'b1; pcm_addr = 18'h00005;
    sdram_ack = 1'b1; sdram_rdy = 1'b1; data_read = 16'hFFFF;
    repeat (3) cyc();
    @(negedge clk);
    checkOutput("rst_rd",   {31'd0, sdram_rd}, 32'd0);
    checkOutput("rst_addr", {10'd0, sdram_addr}, 32'd0);
    checkOutput("rst_ok",   {31'd0, pcm_ok}, 32'd0);
    checkOutput("rst_data", {24'd0, pcm_data}, 32'd0);
    cyc();
    rst = 1'b0; sdram_ack = 1'b0; sdram_rdy = 1'b0; data_read = 16'h0;

    // Demand fetch of word 2, odd byte.
    serveFetch(22'h10002, 16'hA55A, 1'b1, "demand5");
    @(negedge clk);
    checkOutput("demand5_ok",   {31'd0, pcm_ok}, 32'd1);
    checkOutput("demand5_data", {24'd0, pcm_data}, 32'h00A5);

    // Prefetch of word 3, then a P hit.
    serveFetch(22'h10003, 16'h1234, 1'b0, "pref3");
    pcm_addr = 18'h00006;
    @(negedge clk);
    checkOutput("phit_okBefore", {31'd0, pcm_ok}, 32'd0);
    cyc();
    @(negedge clk);
    checkOutput("phit_ok",   {31'd0, pcm_ok}, 32'd1);
    checkOutput("phit_data", {24'd0, pcm_data}, 32'h0034);
    checkOutput("phit_noRd", {31'd0, sdram_rd}, 32'd0);
    serveFetch(22'h10004, 16'h5678, 1'b0, "pref4");

    // Top word: prefetch must wrap to word 0.
    pcm_addr = 18'h3FFFF;
    serveFetch(22'h2FFFF, 16'hBEEF, 1'b1, "demandTop");
    @(negedge clk);
    checkOutput("demandTop_data", {24'd0, pcm_data}, 32'h00BE);
    serveFetch(22'h10000, 16'h7788, 1'b0, "prefWrap");

    // Address moves while a demand is in WAIT.
    cyc();
    pcm_addr = 18'h00005;
    waitReq(22'h10002, "redirect");
    cyc(); sdram_ack = 1'b1;
    cyc(); sdram_ack = 1'b0; pcm_addr = 18'h00100;
    cyc(); sdram_rdy = 1'b1; data_read = 16'hA55A;
    cyc(); sdram_rdy = 1'b0;
    @(negedge clk);
    checkOutput("redirect_okLow", {31'd0, pcm_ok}, 32'd0);
    serveFetch(22'h10080, 16'hCAFE, 1'b1, "demand100");
    @(negedge clk);
    checkOutput("demand100_ok",   {31'd0, pcm_ok}, 32'd1);
    checkOutput("demand100_data", {24'd0, pcm_data}, 32'h00FE);

    // Reset while a prefetch is in WAIT; the late rdy must be ignored.
    waitReq(22'h10081, "pref81");
    cyc(); sdram_ack = 1'b1;
    cyc(); sdram_ack = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("midRst_ok",   {31'd0, pcm_ok}, 32'd0);
    checkOutput("midRst_data", {24'd0, pcm_data}, 32'd0);
    checkOutput("midRst_rd",   {31'd0, sdram_rd}, 32'd0);
    checkOutput("midRst_addr", {10'd0, sdram_addr}, 32'd0);
    cyc(); cyc();
    rst = 1'b0; pcm_cs = 1'b0; sdram_rdy = 1'b1; data_read = 16'h1111;
    cyc(); sdram_rdy = 1'b0;
    @(negedge clk);
    checkOutput("postRst_rd", {31'd0, sdram_rd}, 32'd0);
    cyc();
    pcm_cs = 1'b1; pcm_addr = 18'h00102;
    @(negedge clk);
    checkOutput("postRst_noValid", {31'd0, pcm_ok}, 32'd0);
    serveFetch(22'h10081, 16'h5566, 1'b1, "refetch81");
    @(negedge clk);
    checkOutput("refetch81_data", {24'd0, pcm_data}, 32'h0066);
    serveFetch(22'h10082, 16'h0F0F, 1'b0, "pref82");

    // Chip select low: no fetch even on a miss.
    pcm_cs = 1'b0; pcm_addr = 18'h20000;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (sdram_rd) seen++;
    end
    checkOutput("csLow_noRd", seen, 32'd0);
    cyc();
    pcm_cs = 1'b1;
    serveFetch(22'h20000, 16'h9ABC, 1'b1, "csHigh");
    @(negedge clk);
    checkOutput("csHigh_data", {24'd0, pcm_data}, 32'h00BC);

    // Random playback.
    cyc();
    rst = 1'b1; pcm_cs = 1'b0;
    repeat (2) cyc();
    rst = 1'b0; autoMem = 1'b1; scoreOn = 1'b1;
    curAddr = 18'($urandom);
    for (int t = 0; t < 250; t++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      curAddr = curAddr + 18'd1;
      else if (r < 63) curAddr = curAddr;
      else if (r < 78) curAddr = curAddr + 18'($urandom_range(2, 5));
      else if (r < 90) curAddr = 18'($urandom);
      else             curAddr = 18'h3FFF0 + 18'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        pcm_cs = 1'b0;
        pcm_addr = 18'($urandom);
        repeat ($urandom_range(1, 6)) cyc();
        @(negedge clk);
        checkOutput("okCsLow", {31'd0, pcm_ok}, 32'd0);
        cyc();
      end
      applyStimulus(curAddr);
    end
    repeat (4) cyc();
    checkOutput("queueEmpty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
